// File: rtl/mem_noc_rr_arb.sv
// Round-robin arbiter for N memory masters onto one in-order slave port.
// An ID FIFO records who issued each outstanding request so response bursts route back in order.
package mem_noc_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        last;
    } mem_resp_t;
endpackage

module mem_noc_rr_arb
    import mem_noc_pkg::*;
#(
    parameter int N      = 4,
    parameter int MAX_OS = 4,
    parameter int IDW    = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              mn_req_valid,
    output logic [N-1:0]              mn_req_ready,
    input  mem_req_t                  mn_req [N],
    output logic [N-1:0]              mn_resp_valid,
    input  logic [N-1:0]              mn_resp_ready,
    output mem_resp_t                 mn_resp [N],
    output logic                      sn_req_valid,
    input  logic                      sn_req_ready,
    output mem_req_t                  sn_req,
    input  logic                      sn_resp_valid,
    output logic                      sn_resp_ready,
    input  mem_resp_t                 sn_resp,
    output logic [$clog2(MAX_OS):0]   os_cnt
);

    localparam int PW = $clog2(MAX_OS);
    localparam int CW = PW + 1;

    // Handshake rule on every channel: a beat transfers on a rising clk edge
    // where valid and ready are both 1; valid never waits on ready.

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           hold_q, hold_d;
    logic [IDW-1:0] hold_id_q, hold_id_d;
    logic [IDW-1:0] fifo_q [MAX_OS];
    logic [IDW-1:0] fifo_d [MAX_OS];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  os_cnt_q, os_cnt_d;

    logic           cand_vld;
    logic [IDW-1:0] cand_id;
    logic           fifo_full;
    logic           fifo_nempty;
    logic [IDW-1:0] head_id;
    logic           req_fire;
    logic           resp_pop;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    assign fifo_full   = (os_cnt_q == CW'(MAX_OS));
    assign fifo_nempty = (os_cnt_q != '0);
    assign head_id     = fifo_q[rd_ptr_q];
    assign os_cnt      = os_cnt_q;

    // A stalled grant is pinned to hold_id so the slave sees a stable request.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        if (hold_q) begin
            cand_vld = 1'b1;
            cand_id  = hold_id_q;
        end else begin
            // Descending scan: the last hit is the nearest master at or after rr_ptr.
            for (int k = N - 1; k >= 0; k--) begin
                if (mn_req_valid[wrap_add(rr_ptr_q, k)]) begin
                    cand_vld = 1'b1;
                    cand_id  = wrap_add(rr_ptr_q, k);
                end
            end
        end
    end

    assign sn_req_valid = cand_vld && !fifo_full;
    assign req_fire     = sn_req_valid && sn_req_ready;
    assign resp_pop     = sn_resp_valid && sn_resp_ready && sn_resp.last;

    always_comb begin
        sn_req       = '0;
        mn_req_ready = '0;
        if (cand_vld) sn_req = mn_req[cand_id];
        if (req_fire) mn_req_ready[cand_id] = 1'b1;
    end

    always_comb begin
        mn_resp_valid = '0;
        sn_resp_ready = 1'b0;
        for (int i = 0; i < N; i++) mn_resp[i] = '0;
        if (fifo_nempty) begin
            mn_resp_valid[head_id] = sn_resp_valid;
            mn_resp[head_id]       = sn_resp;
            sn_resp_ready          = mn_resp_ready[head_id];
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        hold_id_d = hold_id_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        os_cnt_d  = os_cnt_q;
        if (req_fire) begin
            fifo_d[wr_ptr_q] = cand_id;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            rr_ptr_d         = (cand_id == IDW'(N - 1)) ? '0 : cand_id + 1'b1;
            hold_d           = 1'b0;
        end else if (sn_req_valid) begin
            hold_d    = 1'b1;
            hold_id_d = cand_id;
        end
        if (resp_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({req_fire, resp_pop})
            2'b10:   os_cnt_d = os_cnt_q + 1'b1;
            2'b01:   os_cnt_d = os_cnt_q - 1'b1;
            default: os_cnt_d = os_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            hold_q    <= 1'b0;
            hold_id_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            os_cnt_q  <= '0;
            for (int i = 0; i < MAX_OS; i++) fifo_q[i] <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            hold_id_q <= hold_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            os_cnt_q  <= os_cnt_d;
            for (int i = 0; i < MAX_OS; i++) fifo_q[i] <= fifo_d[i];
        end
    end

    // Responses with nothing outstanding are a slave protocol error.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(sn_resp_valid && os_cnt_q == '0));

endmodule
